// File: rtl/cpu_pkg.sv
// Shared types for the multicycle accumulator CPU: opcode and FSM state
// encodings plus small decode helpers.
package cpu_pkg;

    localparam int OPW = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_NOT = 4'h7,
        OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_LDI = 4'hB,
        OP_SHL = 4'hC, OP_SHR = 4'hD, OP_RSV = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_e;

    function automatic int instWidth(input int aw);
        return aw + OPW;
    endfunction

    // LDA..OR all touch data memory; the encodings are contiguous.
    function automatic logic isMemOp(input opcode_e op);
        return (op >= OP_LDA) && (op <= OP_OR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU. Shift ops exist only when CPU_SHIFT_EN is
// defined; otherwise SHL/SHR fall to the pass-through default.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] b,
    input  opcode_e       op,
    input  logic          carryIn,
    output logic [DW-1:0] result,
    output logic          carryOut
);

    always_comb begin
        result   = acc;
        carryOut = carryIn;
        case (op)
            OP_LDA: result = b;
            OP_ADD: {carryOut, result} = {1'b0, acc} + {1'b0, b};
            OP_SUB: begin
                result   = acc - b;
                carryOut = (acc < b);
            end
            OP_AND: result = acc & b;
            OP_OR:  result = acc | b;
            OP_NOT: result = ~acc;
`ifdef CPU_SHIFT_EN
            OP_SHL: begin
                result   = {acc[DW-2:0], 1'b0};
                carryOut = acc[DW-1];
            end
            OP_SHR: begin
                result   = {1'b0, acc[DW-1:1]};
                carryOut = acc[0];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator CPU with ready-handshaked data memory and Z/C flags.
// Define CPU_SHIFT_EN to enable the SHL/SHR opcodes.
module acc_cpu_mc
    import cpu_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int AW = 4,
    localparam int IW = instWidth(AW)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [AW-1:0] instMemAddrBus,
    input  logic [IW-1:0] instMemDataBus,
    output logic [AW-1:0] dataMemAddrBus,
    output logic [DW-1:0] dataMemInDataBus,
    input  logic [DW-1:0] dataMemOutDataBus,
    input  logic          dataMemReady,
    output logic          mReadFlag,
    output logic          mWriteFlag,
    output logic [DW-1:0] accOut,
    output logic [DW-1:0] aluOut,
    output logic [3:0]    opcode,
    output logic          zeroFlag,
    output logic          carryFlag,
    output logic          halted
);

    state_e        state, nextState;
    logic [AW-1:0] pc, pcNext;
    logic [IW-1:0] ir;
    logic [DW-1:0] acc, accNext, aluRes;
    logic          zf, cf, carryNext, aluCarry;
    logic          irWe, pcWe, accWe;
    opcode_e       op;
    logic [AW-1:0] operand;

    assign op      = opcode_e'(ir[IW-1:AW]);
    assign operand = ir[AW-1:0];

    cpu_alu #(.DW(DW)) uAlu (
        .acc      (acc),
        .b        (dataMemOutDataBus),
        .op       (op),
        .carryIn  (cf),
        .result   (aluRes),
        .carryOut (aluCarry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH: nextState = EXEC;
            EXEC: begin
                if (isMemOp(op))       nextState = MEM;
                else if (op == OP_HLT) nextState = HALT;
                else                   nextState = FETCH;
            end
            MEM:     if (dataMemReady) nextState = FETCH;
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    // Strobes and datapath enables are pure decodes of state/IR, so an
    // asynchronous reset of the state register drops them immediately.
    always_comb begin
        mReadFlag  = 1'b0;
        mWriteFlag = 1'b0;
        halted     = 1'b0;
        irWe       = 1'b0;
        pcWe       = 1'b0;
        pcNext     = pc + 1'b1;
        accWe      = 1'b0;
        accNext    = aluRes;
        carryNext  = aluCarry;
        case (state)
            FETCH: begin
                irWe = 1'b1;
                pcWe = 1'b1;
            end
            EXEC: begin
                case (op)
                    OP_NOT: accWe = 1'b1;
`ifdef CPU_SHIFT_EN
                    OP_SHL, OP_SHR: accWe = 1'b1;
`endif
                    OP_LDI: begin
                        accWe     = 1'b1;
                        accNext   = DW'(operand);
                        carryNext = cf;
                    end
                    OP_JMP: begin
                        pcWe   = 1'b1;
                        pcNext = operand;
                    end
                    OP_JZ: begin
                        pcWe   = zf;
                        pcNext = operand;
                    end
                    OP_JC: begin
                        pcWe   = cf;
                        pcNext = operand;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mReadFlag  = (op != OP_STA);
                mWriteFlag = (op == OP_STA);
                accWe      = dataMemReady && (op != OP_STA);
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
            zf  <= 1'b0;
            cf  <= 1'b0;
        end else begin
            if (irWe) ir <= instMemDataBus;
            if (pcWe) pc <= pcNext;
            if (accWe) begin
                acc <= accNext;
                zf  <= (accNext == '0);
                cf  <= carryNext;
            end
        end
    end

    assign instMemAddrBus   = pc;
    assign dataMemAddrBus   = operand;
    assign dataMemInDataBus = acc;
    assign accOut           = acc;
    assign aluOut           = aluRes;
    assign opcode           = ir[IW-1:AW];
    assign zeroFlag         = zf;
    assign carryFlag        = cf;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: directed programs plus random ROM images checked
// instruction by instruction against an ISA-level model.
module tb_acc_cpu_mc;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int IW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] instMemAddrBus, dataMemAddrBus;
    logic [IW-1:0] instMemDataBus;
    logic [DW-1:0] dataMemInDataBus, dataMemOutDataBus, accOut, aluOut;
    logic          dataMemReady, mReadFlag, mWriteFlag, zeroFlag, carryFlag, halted;
    logic [3:0]    opcode;

    logic [IW-1:0] rom  [16];
    logic [DW-1:0] dmem [16];

    assign instMemDataBus    = rom[instMemAddrBus];
    assign dataMemOutDataBus = dmem[dataMemAddrBus];

    always #5 clock = ~clock;

    acc_cpu_mc #(.DW(DW), .AW(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .instMemAddrBus    (instMemAddrBus),
        .instMemDataBus    (instMemDataBus),
        .dataMemAddrBus    (dataMemAddrBus),
        .dataMemInDataBus  (dataMemInDataBus),
        .dataMemOutDataBus (dataMemOutDataBus),
        .dataMemReady      (dataMemReady),
        .mReadFlag         (mReadFlag),
        .mWriteFlag        (mWriteFlag),
        .accOut            (accOut),
        .aluOut            (aluOut),
        .opcode            (opcode),
        .zeroFlag          (zeroFlag),
        .carryFlag         (carryFlag),
        .halted            (halted)
    );

    int   nAsserts = 0;
    int   nFail    = 0;
    int   readyDelay, waitCnt, strobeCycles;
    logic readyNoise, bothSeen;
    string curTest;

    // ISA-level reference state
    int   mPc, mAcc, mOp;
    logic mZ, mC, mHalted;
    int   mMem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s/%s: observed %0h expected %0h", curTest, tag, obs, exp);
        end
    endtask

    // One clock of the memory responder; returns at posedge+1.
    task automatic tick();
        logic strobe;
        @(negedge clock);
        strobe = mReadFlag | mWriteFlag;
        if (mReadFlag && mWriteFlag) bothSeen = 1'b1;
        if (strobe) strobeCycles++;
        dataMemReady = strobe ? (waitCnt >= readyDelay) : readyNoise;
        if (mWriteFlag && dataMemReady) dmem[dataMemAddrBus] = dataMemInDataBus;
        waitCnt = (strobe && !dataMemReady) ? waitCnt + 1 : 0;
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        mPc = 0; mAcc = 0; mOp = 0; mZ = 0; mC = 0; mHalted = 0;
    endtask

    task automatic modelStep(output int cyc, output int strobes);
        int instr, opd, sum;
        logic wr;
        instr = int'(rom[mPc]);
        mOp   = instr / 16;
        opd   = instr % 16;
        mPc   = (mPc + 1) % 16;
        wr    = 1'b0;
        cyc   = 2;
        strobes = 0;
        if (mOp >= 1 && mOp <= 6) begin
            cyc     = 3 + readyDelay;
            strobes = 1 + readyDelay;
        end
        case (mOp)
            1:  begin mAcc = mMem[opd]; wr = 1; end
            2:  mMem[opd] = mAcc;
            3:  begin sum = mAcc + mMem[opd]; mC = (sum > 255); mAcc = sum % 256; wr = 1; end
            4:  begin mC = (mAcc < mMem[opd]); mAcc = (mAcc - mMem[opd] + 256) % 256; wr = 1; end
            5:  begin mAcc = mAcc & mMem[opd]; wr = 1; end
            6:  begin mAcc = mAcc | mMem[opd]; wr = 1; end
            7:  begin mAcc = 255 - mAcc; wr = 1; end
            8:  mPc = opd;
            9:  if (mZ) mPc = opd;
            10: if (mC) mPc = opd;
            11: begin mAcc = opd; wr = 1; end
`ifdef CPU_SHIFT_EN
            12: begin mC = (mAcc >= 128); mAcc = (mAcc * 2) % 256; wr = 1; end
            13: begin mC = (mAcc % 2 == 1); mAcc = mAcc / 2; wr = 1; end
`endif
            15: mHalted = 1;
            default: ;
        endcase
        if (wr) mZ = (mAcc == 0);
    endtask

    task automatic setMem(input int idx, input int val);
        dmem[idx] = DW'(val);
        mMem[idx] = val;
    endtask

    task automatic clearImage();
        for (int i = 0; i < 16; i++) begin
            rom[i] = '0;
            setMem(i, 0);
        end
    endtask

    // Mid-cycle asynchronous reset, checked before the next clock edge.
    task automatic doReset();
        #2 reset = 1'b1;
        #1;
        chk("rst pc", instMemAddrBus, 0);
        chk("rst acc", accOut, 0);
        chk("rst z", zeroFlag, 0);
        chk("rst c", carryFlag, 0);
        chk("rst halted", halted, 0);
        chk("rst rd", mReadFlag, 0);
        chk("rst wr", mWriteFlag, 0);
        chk("rst opcode", opcode, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        waitCnt = 0;
        dataMemReady = 1'b0;
        modelReset();
    endtask

    task automatic runInstr(input int n);
        int cyc, st, frozenPc;
        for (int i = 0; i < n; i++) begin
            if (mHalted) break;
            modelStep(cyc, st);
            strobeCycles = 0;
            bothSeen = 1'b0;
            repeat (cyc) tick();
            chk("pc", instMemAddrBus, mPc);
            chk("acc", accOut, mAcc);
            chk("z", zeroFlag, mZ);
            chk("c", carryFlag, mC);
            chk("opcode", opcode, mOp);
            chk("halted", halted, mHalted);
            chk("strobeCycles", strobeCycles, st);
            chk("bothStrobes", bothSeen, 0);
        end
        if (mHalted) begin
            frozenPc = mPc;
            strobeCycles = 0;
            repeat (20) tick();
            chk("hold pc", instMemAddrBus, frozenPc);
            chk("hold halted", halted, 1);
            chk("hold strobes", strobeCycles, 0);
            chk("hold acc", accOut, mAcc);
        end
    endtask

    initial begin
        readyDelay = 0; readyNoise = 1'b0; waitCnt = 0; dataMemReady = 1'b0;
        strobeCycles = 0; bothSeen = 1'b0;

        curTest = "basic";
        clearImage();
        rom[0] = 8'hB5; rom[1] = 8'h23; rom[2] = 8'h13; rom[3] = 8'h33; rom[4] = 8'hF0;
        doReset();
        runInstr(4);
        chk("acc 0A", accOut, 8'h0A);
        chk("z 0", zeroFlag, 0);
        chk("c 0", carryFlag, 0);
        chk("mem3", dmem[3], 8'h05);
        runInstr(1);

        curTest = "addWait";
        clearImage();
        setMem(0, 8'hFF); setMem(1, 8'h01);
        rom[0] = 8'h10; rom[1] = 8'h31; rom[2] = 8'h99; rom[9] = 8'hF0;
        readyDelay = 4;
        doReset();
        runInstr(2);
        chk("strobe 5", strobeCycles, 5);
        chk("acc 00", accOut, 8'h00);
        chk("z 1", zeroFlag, 1);
        chk("c 1", carryFlag, 1);
        runInstr(1);
        chk("jz pc 9", instMemAddrBus, 9);
        runInstr(1);

        curTest = "subJc";
        clearImage();
        setMem(0, 3); setMem(1, 5);
        rom[0] = 8'h10; rom[1] = 8'h41; rom[2] = 8'hA2;
        readyDelay = 1;
        doReset();
        runInstr(2);
        chk("acc FE", accOut, 8'hFE);
        chk("c 1", carryFlag, 1);
        runInstr(4);
        chk("loop pc", instMemAddrBus, 2);

        curTest = "wrap";
        clearImage();
        rom[0] = 8'h8E;
        readyDelay = 0;
        doReset();
        runInstr(3);
        chk("wrap pc 0", instMemAddrBus, 0);

        curTest = "shift";
        clearImage();
        setMem(0, 1); setMem(1, 2); setMem(2, 8'h81);
        rom[0] = 8'h10; rom[1] = 8'h41; rom[2] = 8'h12; rom[3] = 8'hC0; rom[4] = 8'hD0; rom[5] = 8'hF0;
        doReset();
        runInstr(4);
`ifdef CPU_SHIFT_EN
        chk("shl acc", accOut, 8'h02);
        chk("shl c", carryFlag, 1);
`else
        chk("shl acc", accOut, 8'h81);
        chk("shl c", carryFlag, 1);
`endif
        runInstr(1);
`ifdef CPU_SHIFT_EN
        chk("shr acc", accOut, 8'h01);
        chk("shr c", carryFlag, 0);
`else
        chk("shr acc", accOut, 8'h81);
        chk("shr c", carryFlag, 1);
`endif
        runInstr(1);

        curTest = "rstInMem";
        clearImage();
        setMem(0, 8'h5A);
        rom[0] = 8'h10;
        readyDelay = 10;
        doReset();
        tick(); tick();
        chk("rd in mem", mReadFlag, 1);
        chk("aluOut lda", aluOut, 8'h5A);
        #2 reset = 1'b1;
        #1;
        chk("rd dropped", mReadFlag, 0);
        chk("acc kept 0", accOut, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        waitCnt = 0;
        modelReset();
        readyDelay = 0;
        runInstr(3);

        for (int p = 0; p < 8; p++) begin
            curTest = $sformatf("rand%0d", p);
            readyDelay = $urandom_range(0, 3);
            readyNoise = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                rom[i] = IW'($urandom_range(0, 255));
                setMem(i, $urandom_range(0, 255));
            end
            doReset();
            runInstr(12);
            if (p == 3) doReset();
            runInstr(20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
